// File: rtl/busca_instrucao.sv
// rtl/busca_instrucao.sv - instruction fetch/hold stage feeding the immediate extender
// Fetches one word per start, decodes the immediate type and holds it until acked.
module busca_instrucao #(
   parameter int          TIMEOUT_CYC = 16,
   parameter logic [31:0] RESET_INSTR = 32'h00000013
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [63:0] pc,
   output logic        mem_req,
   output logic [63:0] mem_addr,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata,
   output logic [31:0] instr,
   output logic [3:0]  imm_sel,
   output logic        instr_valid,
   input  logic        instr_ack,
   output logic        illegal,
   output logic        fetch_err,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, FETCH, HOLD, ERROR} state_t;

   state_t      state_q;
   logic [31:0] instr_q;
   logic [3:0]  imm_sel_q;
   logic [63:0] mem_addr_q;
   logic        mem_req_q;
   logic        instr_valid_q;
   logic        illegal_q;
   logic        fetch_err_q;
   logic [7:0]  cnt_q;

   logic [3:0]  imm_sel_d;
   logic        illegal_d;

   // Decoded straight from the memory word so the select is ready the cycle instr loads.
   always_comb begin
      imm_sel_d = 4'd0;
      illegal_d = 1'b0;
      case (mem_rdata[6:0])
         7'b0000011, 7'b0010011, 7'b0011011,
         7'b1100111, 7'b1110011: imm_sel_d = 4'd0;
         7'b0100011:             imm_sel_d = 4'd1;
         7'b1100011:             imm_sel_d = 4'd2;
         7'b0110111, 7'b0010111: imm_sel_d = 4'd3;
         7'b0110011, 7'b0111011: imm_sel_d = 4'd0;
         default:                illegal_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= IDLE;
         instr_q       <= RESET_INSTR;
         imm_sel_q     <= 4'd0;
         mem_addr_q    <= 64'd0;
         mem_req_q     <= 1'b0;
         instr_valid_q <= 1'b0;
         illegal_q     <= 1'b0;
         fetch_err_q   <= 1'b0;
         cnt_q         <= 8'd0;
      end else begin
         case (state_q)
            IDLE, ERROR: begin
               if (start) begin
                  mem_addr_q  <= pc;
                  cnt_q       <= 8'd0;
                  mem_req_q   <= 1'b1;
                  fetch_err_q <= 1'b0;
                  state_q     <= FETCH;
               end
            end
            FETCH: begin
               // A response arriving on the last allowed cycle still counts.
               if (mem_ready) begin
                  instr_q       <= mem_rdata;
                  imm_sel_q     <= imm_sel_d;
                  illegal_q     <= illegal_d;
                  mem_req_q     <= 1'b0;
                  instr_valid_q <= 1'b1;
                  state_q       <= HOLD;
               end else if (cnt_q == 8'(TIMEOUT_CYC - 1)) begin
                  mem_req_q   <= 1'b0;
                  fetch_err_q <= 1'b1;
                  state_q     <= ERROR;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            HOLD: begin
               if (instr_ack) begin
                  instr_valid_q <= 1'b0;
                  state_q       <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign mem_req     = mem_req_q;
   assign mem_addr    = mem_addr_q;
   assign instr       = instr_q;
   assign imm_sel     = imm_sel_q;
   assign instr_valid = instr_valid_q;
   assign illegal     = illegal_q;
   assign fetch_err   = fetch_err_q;
   assign busy        = (state_q == FETCH) || (state_q == HOLD);

endmodule

// File: tb/tb_busca_instrucao.sv
// tb/tb_busca_instrucao.sv - directed vector bench for busca_instrucao
// Inputs are driven and outputs sampled on the falling edge.
module tb_busca_instrucao;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [63:0] pc;
   logic        mem_req;
   logic [63:0] mem_addr;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic [31:0] instr;
   logic [3:0]  imm_sel;
   logic        instr_valid;
   logic        instr_ack;
   logic        illegal;
   logic        fetch_err;
   logic        busy;

   int total = 0;
   int bad   = 0;

   busca_instrucao #(.TIMEOUT_CYC(4), .RESET_INSTR(32'h00000013)) dut (
      .clk(clk), .reset(reset), .start(start), .pc(pc),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
      .instr(instr), .imm_sel(imm_sel), .instr_valid(instr_valid), .instr_ack(instr_ack),
      .illegal(illegal), .fetch_err(fetch_err), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] word;
      int          delay;
      logic [3:0]  exp_sel;
      logic        exp_ill;
   } vec_t;

   vec_t vecs[9];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Leaves the DUT in HOLD, at a falling edge, with the word latched.
   task automatic do_fetch(input logic [63:0] p, input logic [31:0] w, input int d);
      @(negedge clk);
      start = 1'b1;
      pc    = p;
      @(negedge clk);
      start = 1'b0;
      check("mem_req_on", mem_req, 1);
      check("mem_addr", mem_addr, p);
      check("busy_fetch", busy, 1);
      repeat (d) @(negedge clk);
      check("valid_before_ready", instr_valid, 0);
      mem_ready = 1'b1;
      mem_rdata = w;
      @(negedge clk);
      mem_ready = 1'b0;
      mem_rdata = 32'hDEADBEEF;
      check("instr_valid", instr_valid, 1);
      check("mem_req_off", mem_req, 0);
      check("instr", instr, w);
   endtask

   task automatic do_ack();
      instr_ack = 1'b1;
      @(negedge clk);
      instr_ack = 1'b0;
      check("valid_after_ack", instr_valid, 0);
      check("busy_after_ack", busy, 0);
   endtask

   initial begin
      vecs[0] = '{32'hFFC10093, 1, 4'd0, 1'b0};
      vecs[1] = '{32'h00A12423, 0, 4'd1, 1'b0};
      vecs[2] = '{32'hFE0008E3, 0, 4'd2, 1'b0};
      vecs[3] = '{32'h123450B7, 2, 4'd3, 1'b0};
      vecs[4] = '{32'h0000006F, 0, 4'd0, 1'b1};
      vecs[5] = '{32'h00000097, 1, 4'd3, 1'b0};
      vecs[6] = '{32'h00B50533, 0, 4'd0, 1'b0};
      vecs[7] = '{32'h0000007F, 0, 4'd0, 1'b1};
      vecs[8] = '{32'h00053503, 3, 4'd0, 1'b0};

      reset = 1'b0; start = 1'b0; pc = 64'd0;
      mem_ready = 1'b0; mem_rdata = 32'd0; instr_ack = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_instr", instr, 32'h00000013);
      check("rst_imm_sel", imm_sel, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_flags", {mem_req, instr_valid, illegal, fetch_err, busy}, 0);
      reset = 1'b1;

      // Last entry answers on the timeout cycle, so the response must win.
      for (int i = 0; i < 9; i++) begin
         do_fetch(64'h100 + 64'(4 * i), vecs[i].word, vecs[i].delay);
         check("imm_sel", imm_sel, vecs[i].exp_sel);
         check("illegal", illegal, vecs[i].exp_ill);
         check("no_err", fetch_err, 0);
         do_ack();
         check("instr_retained", instr, vecs[i].word);
      end

      // Memory never answers: four FETCH cycles then ERROR.
      @(negedge clk);
      start = 1'b1;
      pc    = 64'h2000;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      check("to_not_yet", {fetch_err, mem_req}, 2'b01);
      @(negedge clk);
      check("to_err", fetch_err, 1);
      check("to_req", mem_req, 0);
      check("to_busy", busy, 0);
      repeat (3) @(negedge clk);
      check("err_sticky", {fetch_err, instr_valid}, 2'b10);
      do_fetch(64'h2004, 32'h00A12423, 1);
      check("err_cleared", fetch_err, 0);
      check("err_recover_sel", imm_sel, 1);

      // Held instruction must not move while ack is withheld.
      for (int i = 0; i < 10; i++) begin
         start     = i[0];
         mem_ready = ~i[0];
         mem_rdata = 32'h0000006F ^ (32'h01010101 * 32'(i));
         pc        = 64'h3000 + 64'(i);
         @(negedge clk);
         check("hold_stable", {instr_valid, mem_req, imm_sel, instr},
               {1'b1, 1'b0, 4'd1, 32'h00A12423});
      end
      mem_ready = 1'b0;
      start     = 1'b1;
      do_ack();
      start = 1'b0;
      repeat (3) @(negedge clk);
      check("ack_start_idle", {mem_req, busy, instr_valid}, 3'b000);
      check("ack_start_addr", mem_addr, 64'h2004);

      // Asynchronous reset between edges in FETCH.
      start = 1'b1;
      pc    = 64'h4000;
      @(posedge clk);
      #2 start = 1'b0;
      check("pre_rst_req", mem_req, 1);
      reset = 1'b0;
      #1;
      check("async_req", mem_req, 0);
      check("async_instr", instr, 32'h00000013);
      check("async_flags", {busy, instr_valid, mem_addr[15:0]}, 0);
      @(negedge clk);
      mem_ready = 1'b1;
      mem_rdata = 32'h00A12423;
      reset     = 1'b1;
      repeat (2) @(negedge clk);
      check("stale_ready", {instr_valid, busy, mem_req}, 3'b000);
      check("stale_instr", instr, 32'h00000013);
      mem_ready = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
